// File: rtl/perm_unscatter.sv
// perm_unscatter: reorders 32-beat frames from permuted stream order into natural order.
// Define PERM_UNSCATTER_PINGPONG_EN for two banks so one frame fills while another drains.
module perm_unscatter #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state;
    logic [4:0] in_cnt, rd_cnt, slot;
    logic [1:0] mode_q, cur_mode;
    logic in_fire, in_done, out_fire, out_done, start;
`ifdef PERM_UNSCATTER_PINGPONG_EN
    localparam int AW = 6;
    logic [AW-1:0] wa, ra;
    logic rd_bank, pend, nxt_bank;
    // Draining always hands over to the other bank, whether it is full or still filling.
    assign nxt_bank = rd_bank ^ out_done;
    assign in_ready = state == FILL || !pend;
    assign start = (in_done && state == FILL) || (out_done && (pend || in_done));
    assign wa = {rd_bank ^ (state == DRAIN), slot};
    assign ra = {start ? nxt_bank : rd_bank, start ? 5'd0 : rd_cnt + 5'd1};
    always_ff @(posedge clk)
        if (rst) begin
            rd_bank <= 1'b0;
            pend <= 1'b0;
        end else begin
            rd_bank <= nxt_bank;
            pend <= (pend || (state == DRAIN && in_done)) && !out_done;
        end
`else
    localparam int AW = 5;
    logic [AW-1:0] wa, ra;
    assign in_ready = state == FILL;
    assign start = in_done;
    assign wa = slot;
    assign ra = start ? 5'd0 : rd_cnt + 5'd1;
`endif
    logic [DATA_WIDTH-1:0] mem [2**AW];
    assign in_fire = in_valid && in_ready;
    assign in_done = in_fire && in_cnt == 5'(FRAME - 1);
    assign out_fire = out_valid && out_ready;
    assign out_done = out_fire && out_last;
    assign cur_mode = in_cnt == 5'd0 ? in_mode : mode_q;
    always_comb
        slot = cur_mode == 2'd1 ? {in_cnt[4:3], in_cnt[1:0], in_cnt[2]} :
               cur_mode == 2'd3 ? in_cnt : {in_cnt[1:0], in_cnt[4:2]};
    always_ff @(posedge clk)
        if (in_fire) mem[wa] <= in_data;
    // Slot P(31) is 31 in every mode, so slot 0 is always settled when a frame completes.
    always_ff @(posedge clk)
        if (rst) begin
            state <= FILL;
            in_cnt <= 5'd0;
            rd_cnt <= 5'd0;
            mode_q <= 2'd0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
        end else begin
            if (in_fire) in_cnt <= in_cnt + 5'd1;
            if (in_fire && in_cnt == 5'd0) mode_q <= in_mode;
            if (start) begin
                state <= DRAIN;
                rd_cnt <= 5'd0;
                out_valid <= 1'b1;
                out_last <= 1'b0;
                out_data <= mem[ra];
            end else if (out_done) begin
                state <= FILL;
                rd_cnt <= 5'd0;
                out_valid <= 1'b0;
                out_last <= 1'b0;
            end else if (out_fire) begin
                rd_cnt <= rd_cnt + 5'd1;
                out_data <= mem[ra];
                out_last <= rd_cnt == 5'd30;
            end
        end
endmodule

// File: tb/tb_perm_unscatter.sv
// tb_perm_unscatter: random and directed frames checked against a natural-order frame model.
module tb_perm_unscatter;
    localparam int DW = 12;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, out_last;
    logic [DW-1:0] in_data = 0, out_data;
    logic [1:0] in_mode = 0;
    int vectors = 0, errors = 0;
    int rdy_pol = 0;
    int exp_q[$];
    int fbuf[32], nat[32], got[64];
    int fill_n = 0, fmode = 0, out_idx = 0, got_n = 0;
    logic stalled_prev = 0;
    logic [DW-1:0] prev_data = 0;
    logic win = 0;
    int low_cnt = 0, run = 0, max_run = 0, tfirst = -1, tlast = -1, cyc = 0;

    perm_unscatter #(.DATA_WIDTH(DW), .FRAME(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int pidx(input int m, input int k);
        return m == 1 ? (k / 8) * 8 + (k % 4) * 2 + (k / 4) % 2 :
               m == 3 ? k : (k % 4) * 8 + k / 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: event did not happen as required", name);
    endtask

    // Model: collect each accepted frame, scatter it by P(k), expect slots 0..31 in order.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            fill_n = 0;
            out_idx = 0;
            stalled_prev = 0;
        end else begin
            if (stalled_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (!out_valid) chk("last_idle", out_last, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) note_fail("extra_beat");
                else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    chk("out_last", out_last, out_idx == 31);
                end
                if (got_n < 64) got[got_n] = out_data;
                got_n++;
                out_idx = (out_idx + 1) % 32;
            end
            if (in_valid && in_ready) begin
                if (fill_n == 0) fmode = in_mode;
                fbuf[fill_n] = in_data;
                fill_n++;
                if (fill_n == 32) begin
                    for (int k = 0; k < 32; k++) nat[pidx(fmode, k)] = fbuf[k];
                    for (int n = 0; n < 32; n++) exp_q.push_back(nat[n]);
                    fill_n = 0;
                end
            end
            stalled_prev = out_valid && !out_ready;
            prev_data = out_data;
            if (win) begin
                if (!in_ready) begin
                    low_cnt++;
                    run++;
                    if (run > max_run) max_run = run;
                end else run = 0;
                if (out_valid) begin
                    if (tfirst < 0) tfirst = cyc;
                    tlast = cyc;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1 out_ready = rdy_pol == 0 ? 1'b1 : rdy_pol == 1 ? !out_ready : ($urandom_range(99) < 70);
    end

    task automatic send_beat(input int d, input int m, input int gap);
        int t = 0;
        logic acc = 0;
        in_valid = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1;
        in_data = DW'(d);
        in_mode = 2'(m);
        while (!acc && t < 2000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 0;
        if (!acc) note_fail("in_accept_timeout");
    endtask

    task automatic wait_idle();
        int t = 0;
        @(posedge clk);
        #1;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) note_fail("drain_timeout");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        got_n = 0;
        for (int k = 0; k < 32; k++) send_beat(k, 0, 0);
        wait_idle();
        chk("m0_count", got_n, 32);
        chk("m0_beat1", got[1], 4);
        chk("m0_beat7", got[7], 28);
        chk("m0_beat8", got[8], 1);
        chk("m0_beat31", got[31], 31);

        got_n = 0;
        for (int k = 0; k < 32; k++) send_beat(pidx(1, k), 1, 0);
        wait_idle();
        for (int n = 0; n < 32; n++) chk("m1_natural", got[n], n);

        got_n = 0;
        for (int k = 0; k < 31; k++) send_beat(100 + k, k == 0 ? 3 : $urandom_range(3), 0);
        chk("m3_pre_valid", out_valid, 0);
        send_beat(131, $urandom_range(3), 0);
        @(negedge clk);
        chk("m3_latency", out_valid, 1);
        chk("m3_first", out_data, 100);
        wait_idle();
        chk("m3_beat17", got[17], 117);
        chk("m3_beat31", got[31], 131);

        rdy_pol = 1;
        got_n = 0;
        for (int k = 0; k < 32; k++) send_beat($urandom_range(4095), $urandom_range(3), 0);
        wait_idle();
        chk("toggle_count", got_n, 32);
        rdy_pol = 0;

        for (int k = 0; k < 17; k++) send_beat($urandom_range(4095), $urandom_range(3), 0);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        got_n = 0;
        for (int k = 0; k < 32; k++) send_beat(200 + k, k == 0 ? 2 : $urandom_range(3), 0);
        wait_idle();
        chk("m2_count", got_n, 32);
        chk("m2_beat0", got[0], 200);
        chk("m2_beat1", got[1], 204);
        chk("m2_beat8", got[8], 201);
        chk("m2_beat31", got[31], 231);

        low_cnt = 0;
        run = 0;
        max_run = 0;
        tfirst = -1;
        tlast = -1;
        win = 1;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 32; k++) send_beat($urandom_range(4095), $urandom_range(3), 0);
        wait_idle();
        win = 0;
`ifdef PERM_UNSCATTER_PINGPONG_EN
        chk("b2b_in_ready_low", low_cnt, 0);
        chk("b2b_contiguous", tlast - tfirst + 1, 64);
`else
        chk("b2b_low_run", max_run, 32);
        chk("b2b_low_total", low_cnt, 64);
`endif

        rdy_pol = 2;
        for (int f = 0; f < 6; f++)
            for (int k = 0; k < 32; k++)
                send_beat($urandom_range(4095), $urandom_range(3), $urandom_range(2));
        wait_idle();
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/perm_unscatter.md
PERM_UNSCATTER -- requirements
Module: perm_unscatter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, giving the coefficient width.
REQ-002 SHALL have parameter FRAME, default 32, giving the frame length (fixed 32; other values unsupported).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the input beat.
REQ-007 SHALL have port in_data, input, DATA_WIDTH bits: coefficient, arriving in permuted order.
REQ-008 SHALL have port in_mode, input, 2 bits: permutation mode, sampled on the first beat of each frame.
REQ-009 SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream accepts the output beat.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: coefficient, in natural order.
REQ-012 SHALL have port out_last, output, 1 bit: high on output beat 31 of a frame.

Function
REQ-013 SHALL define the forward index P(k) for stream position k (5 bits, k[4:0]) as: mode 0 and mode 2 give {k[1:0],k[4:2]}; mode 1 gives {k[4:3],k[1:0],k[2]}; mode 3 gives k.
REQ-014 SHALL write the input beat at stream position k into buffer slot P(k), using the frame's latched mode.
REQ-015 SHALL transfer an input beat only when in_valid and in_ready are both high, and an output beat only when out_valid and out_ready are both high.
REQ-016 SHALL read slots 0..31 in ascending order during drain, so out_data beat n is the coefficient with natural index n.
REQ-017 SHALL run an FSM with states FILL and DRAIN; FILL moves to DRAIN on accepting input beat 31; DRAIN moves to FILL on output beat 31 being accepted.
REQ-018 SHALL register out_data; out_valid SHALL first rise in the cycle after input beat 31 is accepted (1-cycle latency).
REQ-019 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-020 SHALL wrap the input counter and output counter from 31 to 0, with no extra state.
REQ-021 SHALL ignore in_mode on beats 1..31; a mode change mid-frame SHALL have no effect.
REQ-022 SHALL behave, when input beat 31 and output beat 31 are accepted in the same cycle (ping-pong build only), as a bank swap with no lost cycle.
REQ-023 SHALL drive out_last only while out_valid is high.

Reset
REQ-024 SHALL on rst clear out_valid, out_last and out_data to 0, drive in_ready to 1, zero both counters, set the FSM to FILL, and clear the latched mode to 0.
REQ-025 SHALL discard any partial frame or undrained frame when rst is asserted mid-operation; buffer contents need not be cleared.

Configuration
REQ-026 SHALL, with macro PERM_UNSCATTER_PINGPONG_EN defined, use two 32-entry banks: one fills while the other drains, and in_ready is low only when both banks hold complete undrained frames.
REQ-027 SHALL, without PERM_UNSCATTER_PINGPONG_EN, use one 32-entry bank and hold in_ready low for the whole of DRAIN.

Verification
REQ-028 SHALL cover mode 0, input data = k for k=0..31 with out_ready=1: the output sequence is 0,4,8,...,28,1,5,...,31, which reproduces index n at slot P(k), and out_last is high on beat 31 only.
REQ-029 SHALL cover mode 1, in_data = P(k): out_data = 0,1,2,...,31 in order.
REQ-030 SHALL cover mode 3, in_data = 100+k: out_data = 100..131 unchanged, with out_valid rising 1 cycle after the last input beat.
REQ-031 SHALL cover out_ready toggled 1/0 every cycle during drain: no beat is dropped or duplicated, and out_data is stable while stalled.
REQ-032 SHALL cover rst pulsed after 17 input beats, followed by a full mode-2 frame: only the new frame's 32 beats appear, and they are correctly reordered.
REQ-033 SHALL cover back-to-back frames with in_valid=1 continuously in the ping-pong build: in_ready stays 1 and the frames are output contiguously; in the non-ping-pong build in_ready is 0 for exactly 32 cycles with out_ready=1.
